// File: rtl/tlk_reg_pkg.sv
// Register map, IRQ bit positions and the RX-info entry layout shared by
// the TLK2711 register bank and its per-channel info FIFO.
package tlk_reg_pkg;
  localparam int REG_W = 64;

  localparam logic [11:0] OFF_TX_CFG      = 12'h008;
  localparam logic [11:0] OFF_RX_CFG      = 12'h010;
  localparam logic [11:0] OFF_TX_ADDR     = 12'h020;
  localparam logic [11:0] OFF_TX_LEN      = 12'h028;
  localparam logic [11:0] OFF_TX_PACKET   = 12'h030;
  localparam logic [11:0] OFF_TX_STATUS   = 12'h038;
  localparam logic [11:0] OFF_RX_ADDR     = 12'h040;
  localparam logic [11:0] OFF_RX_STATUS   = 12'h050;
  localparam logic [11:0] OFF_IRQ_STATUS  = 12'h060;
  localparam logic [11:0] OFF_IRQ_MASK    = 12'h068;
  localparam logic [11:0] OFF_RX_INFO     = 12'h070;
  localparam logic [11:0] OFF_RX_INFO_CNT = 12'h078;
  localparam logic [11:0] OFF_SOFT_RST    = 12'h100;

  localparam int IRQ_TX_DONE  = 0;
  localparam int IRQ_RX_FRAME = 1;
  localparam int IRQ_LOSS     = 2;
  localparam int IRQ_OVF      = 3;

  typedef struct packed {
    logic [7:0]  data_type;
    logic        file_end;
    logic        checksum;
    logic [15:0] frame_num;
    logic [15:0] frame_length;
  } rx_info_t;

  localparam int INFO_W = $bits(rx_info_t);
endpackage

// File: rtl/tlk_rx_info_fifo.sv
// Per-channel RX frame report FIFO. A push while full is accepted only when
// a pop happens in the same cycle, so the caller can detect overflow.
module tlk_rx_info_fifo
  import tlk_reg_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = INFO_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/tlk_reg_bank.sv
// TLK2711 multi-channel register bank: per-channel TX/RX config, masked W1C
// interrupts, buffered RX frame reports and a global soft-reset pulse.
module tlk_reg_bank
  import tlk_reg_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_CH          = 2,
  parameter int INFO_DEPTH      = 8,
  parameter int SOFT_RST_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_reg_wen,
  input  logic [15:0]                  i_reg_waddr,
  input  logic [63:0]                  i_reg_wdata,
  input  logic                         i_reg_ren,
  input  logic [15:0]                  i_reg_raddr,
  output logic [63:0]                  o_reg_rdata,
  output logic                         o_reg_rvalid,
  output logic [NUM_CH*ADDR_WIDTH-1:0] o_tx_base_addr,
  output logic [NUM_CH*32-1:0]         o_tx_total_packet,
  output logic [NUM_CH*16-1:0]         o_tx_packet_body,
  output logic [NUM_CH*16-1:0]         o_tx_packet_tail,
  output logic [NUM_CH*16-1:0]         o_tx_body_num,
  output logic [NUM_CH*4-1:0]          o_tx_mode,
  output logic [NUM_CH-1:0]            o_tx_config_done,
  output logic [NUM_CH-1:0]            o_rx_config_done,
  output logic [NUM_CH*ADDR_WIDTH-1:0] o_rx_base_addr,
  input  logic [NUM_CH-1:0]            i_tx_interrupt,
  input  logic [NUM_CH-1:0]            i_rx_interrupt,
  input  logic [NUM_CH-1:0]            i_loss_interrupt,
  input  logic [NUM_CH*16-1:0]         i_rx_frame_length,
  input  logic [NUM_CH*16-1:0]         i_rx_frame_num,
  input  logic [NUM_CH*8-1:0]          i_rx_data_type,
  input  logic [NUM_CH-1:0]            i_rx_file_end_flag,
  input  logic [NUM_CH-1:0]            i_rx_checksum_flag,
  input  logic [NUM_CH*6-1:0]          i_rx_status,
  input  logic [NUM_CH*10-1:0]         i_tx_status,
  input  logic [NUM_CH-1:0]            i_sync_loss,
  input  logic [NUM_CH-1:0]            i_link_loss,
  output logic [NUM_CH-1:0]            o_irq,
  output logic                         o_soft_rst
);
  localparam int SRC_W = $clog2(SOFT_RST_CYCLES + 1);
  localparam int CNT_W = $clog2(INFO_DEPTH) + 1;

  logic [3:0]  wch, rch;
  logic [11:0] woff, roff;
  assign wch  = i_reg_waddr[15:12];
  assign woff = i_reg_waddr[11:0];
  assign rch  = i_reg_raddr[15:12];
  assign roff = i_reg_raddr[11:0];

  // Each channel drives its slice only when the read targets it, so the
  // final mux is an OR and out-of-range channels read as zero.
  logic [NUM_CH-1:0][63:0] chan_rd;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                  wsel, rsel, pop, ovf;
    logic [ADDR_WIDTH-1:0] tx_addr_q, rx_addr_q;
    logic [31:0]           tx_len_q;
    logic [15:0]           tx_body_q, tx_num_q, tx_tail_q;
    logic [3:0]            tx_mode_q, irq_st_q, irq_mask_q, w1c, set_v;
    logic [5:0]            snap_rx_q;
    logic [1:0]            snap_ln_q;
    logic                  irq_q, tx_done_q, rx_done_q;
    logic [63:0]           rd;
    rx_info_t              info_in, info_out;
    logic                  f_full, f_empty;
    logic [CNT_W-1:0]      f_cnt;

    assign wsel = i_reg_wen && (wch == 4'(c));
    assign rsel = i_reg_ren && (rch == 4'(c));
    assign pop  = rsel && (roff == OFF_RX_INFO);
    assign ovf  = i_rx_interrupt[c] && f_full && !pop;

    assign info_in = '{data_type:    i_rx_data_type[c*8 +: 8],
                       file_end:     i_rx_file_end_flag[c],
                       checksum:     i_rx_checksum_flag[c],
                       frame_num:    i_rx_frame_num[c*16 +: 16],
                       frame_length: i_rx_frame_length[c*16 +: 16]};

    tlk_rx_info_fifo #(.DEPTH(INFO_DEPTH), .WIDTH(INFO_W)) u_info (
      .clk(clk), .rst(rst), .push_i(i_rx_interrupt[c]), .data_i(info_in),
      .pop_i(pop), .data_o(info_out), .full_o(f_full), .empty_o(f_empty),
      .count_o(f_cnt)
    );

    assign w1c = (wsel && woff == OFF_IRQ_STATUS) ? i_reg_wdata[3:0] : 4'b0;
    assign set_v[IRQ_TX_DONE]  = i_tx_interrupt[c];
    assign set_v[IRQ_RX_FRAME] = i_rx_interrupt[c];
    assign set_v[IRQ_LOSS]     = i_loss_interrupt[c];
    assign set_v[IRQ_OVF]      = ovf;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tx_addr_q <= '0; rx_addr_q <= '0; tx_len_q <= '0;
        tx_body_q <= '0; tx_num_q <= '0; tx_tail_q <= '0; tx_mode_q <= '0;
        irq_st_q <= '0; irq_mask_q <= '0; snap_rx_q <= '0; snap_ln_q <= '0;
        irq_q <= 1'b0; tx_done_q <= 1'b0; rx_done_q <= 1'b0;
      end else begin
        tx_done_q <= wsel && (woff == OFF_TX_CFG);
        rx_done_q <= wsel && (woff == OFF_RX_CFG);
        // Sources are OR-ed after the clear so a same-cycle event wins.
        irq_st_q  <= (irq_st_q & ~w1c) | set_v;
        irq_q     <= |(irq_st_q & irq_mask_q);
        if (i_loss_interrupt[c]) begin
          snap_rx_q <= i_rx_status[c*6 +: 6];
          snap_ln_q <= {i_sync_loss[c], i_link_loss[c]};
        end
        if (wsel) begin
          case (woff)
            OFF_TX_ADDR:   tx_addr_q <= i_reg_wdata[ADDR_WIDTH-1:0];
            OFF_TX_LEN:    tx_len_q  <= i_reg_wdata[31:0];
            OFF_TX_PACKET: begin
              tx_body_q <= i_reg_wdata[15:0];
              tx_num_q  <= i_reg_wdata[31:16];
              tx_tail_q <= i_reg_wdata[47:32];
              tx_mode_q <= i_reg_wdata[63:60];
            end
            OFF_RX_ADDR:   rx_addr_q  <= i_reg_wdata[ADDR_WIDTH-1:0];
            OFF_IRQ_MASK:  irq_mask_q <= i_reg_wdata[3:0];
            default: ;
          endcase
        end
      end
    end

    always_comb begin
      rd = '0;
      if (rsel) begin
        case (roff)
          OFF_TX_ADDR:     rd = 64'(tx_addr_q);
          OFF_TX_LEN:      rd = {32'b0, tx_len_q};
          OFF_TX_PACKET:   rd = {tx_mode_q, 12'b0, tx_tail_q, tx_num_q, tx_body_q};
          OFF_TX_STATUS:   rd = {4'h9, 50'b0, i_tx_status[c*10 +: 10]};
          OFF_RX_ADDR:     rd = 64'(rx_addr_q);
          OFF_RX_STATUS:   rd = {4'ha, 54'b0, i_rx_status[c*6 +: 6]};
          OFF_IRQ_STATUS:  rd = {50'b0, snap_rx_q, 2'b0, snap_ln_q, irq_st_q};
          OFF_IRQ_MASK:    rd = {60'b0, irq_mask_q};
          OFF_RX_INFO:     rd = f_empty ? 64'b0 : {1'b1, 21'b0, info_out};
          OFF_RX_INFO_CNT: rd = 64'(f_cnt);
          default:         rd = '0;
        endcase
      end
    end

    assign chan_rd[c] = rd;
    assign o_tx_base_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = tx_addr_q;
    assign o_rx_base_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = rx_addr_q;
    assign o_tx_total_packet[c*32 +: 32] = tx_len_q;
    assign o_tx_packet_body[c*16 +: 16]  = tx_body_q;
    assign o_tx_body_num[c*16 +: 16]     = tx_num_q;
    assign o_tx_packet_tail[c*16 +: 16]  = tx_tail_q;
    assign o_tx_mode[c*4 +: 4]           = tx_mode_q;
    assign o_tx_config_done[c]           = tx_done_q;
    assign o_rx_config_done[c]           = rx_done_q;
    assign o_irq[c]                      = irq_q;
  end

  logic [63:0] rdata_d, rdata_q;
  logic        rvalid_q;

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < NUM_CH; k++) rdata_d = rdata_d | chan_rd[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= i_reg_ren;
      if (i_reg_ren) rdata_q <= rdata_d;
    end
  end

  assign o_reg_rdata  = rdata_q;
  assign o_reg_rvalid = rvalid_q;

  // Soft reset ignores the channel field; a re-write reloads the count.
  logic             soft_wr, srst_q;
  logic [SRC_W-1:0] srst_cnt_q;
  assign soft_wr = i_reg_wen && (woff == OFF_SOFT_RST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srst_q     <= 1'b0;
      srst_cnt_q <= '0;
    end else if (soft_wr) begin
      srst_q     <= 1'b1;
      srst_cnt_q <= SRC_W'(SOFT_RST_CYCLES - 1);
    end else if (srst_cnt_q != '0) begin
      srst_cnt_q <= srst_cnt_q - 1'b1;
    end else begin
      srst_q <= 1'b0;
    end
  end

  assign o_soft_rst = srst_q;
endmodule

// File: tb/tb_tlk_reg_bank.sv
// Directed bench for tlk_reg_bank (NUM_CH=2, INFO_DEPTH=8, SOFT_RST_CYCLES=255).
module tb_tlk_reg_bank;
  import tlk_reg_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_reg_wen = 1'b0, i_reg_ren = 1'b0;
  logic [15:0] i_reg_waddr = '0, i_reg_raddr = '0;
  logic [63:0] i_reg_wdata = '0;
  logic [63:0] o_reg_rdata;
  logic        o_reg_rvalid;
  logic [63:0] o_tx_base_addr, o_rx_base_addr, o_tx_total_packet;
  logic [31:0] o_tx_packet_body, o_tx_packet_tail, o_tx_body_num;
  logic [7:0]  o_tx_mode;
  logic [1:0]  o_tx_config_done, o_rx_config_done, o_irq;
  logic        o_soft_rst;
  logic [1:0]  i_tx_interrupt = '0, i_rx_interrupt = '0, i_loss_interrupt = '0;
  logic [31:0] i_rx_frame_length = '0, i_rx_frame_num = '0;
  logic [15:0] i_rx_data_type = '0;
  logic [1:0]  i_rx_file_end_flag = '0, i_rx_checksum_flag = '0;
  logic [11:0] i_rx_status = '0;
  logic [19:0] i_tx_status = '0;
  logic [1:0]  i_sync_loss = '0, i_link_loss = '0;

  int n_tests = 0, n_fail = 0;
  logic [63:0] d;
  int n;

  tlk_reg_bank dut (
    .clk(clk), .rst(rst),
    .i_reg_wen(i_reg_wen), .i_reg_waddr(i_reg_waddr), .i_reg_wdata(i_reg_wdata),
    .i_reg_ren(i_reg_ren), .i_reg_raddr(i_reg_raddr),
    .o_reg_rdata(o_reg_rdata), .o_reg_rvalid(o_reg_rvalid),
    .o_tx_base_addr(o_tx_base_addr), .o_tx_total_packet(o_tx_total_packet),
    .o_tx_packet_body(o_tx_packet_body), .o_tx_packet_tail(o_tx_packet_tail),
    .o_tx_body_num(o_tx_body_num), .o_tx_mode(o_tx_mode),
    .o_tx_config_done(o_tx_config_done), .o_rx_config_done(o_rx_config_done),
    .o_rx_base_addr(o_rx_base_addr),
    .i_tx_interrupt(i_tx_interrupt), .i_rx_interrupt(i_rx_interrupt),
    .i_loss_interrupt(i_loss_interrupt),
    .i_rx_frame_length(i_rx_frame_length), .i_rx_frame_num(i_rx_frame_num),
    .i_rx_data_type(i_rx_data_type), .i_rx_file_end_flag(i_rx_file_end_flag),
    .i_rx_checksum_flag(i_rx_checksum_flag), .i_rx_status(i_rx_status),
    .i_tx_status(i_tx_status), .i_sync_loss(i_sync_loss), .i_link_loss(i_link_loss),
    .o_irq(o_irq), .o_soft_rst(o_soft_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic wr(input logic [3:0] ch, input logic [11:0] off, input logic [63:0] v);
    i_reg_wen = 1'b1; i_reg_waddr = {ch, off}; i_reg_wdata = v;
    tick();
    i_reg_wen = 1'b0;
  endtask

  task automatic rd(input logic [3:0] ch, input logic [11:0] off, output logic [63:0] v);
    i_reg_ren = 1'b1; i_reg_raddr = {ch, off};
    tick();
    i_reg_ren = 1'b0;
    v = o_reg_rdata;
  endtask

  // ch0 report number i: len=i+1, num=0x100+i, type=i, file_end=i[0], checksum=0
  task automatic set_rx(input int i);
    i_rx_frame_length[15:0] = 16'(i + 1);
    i_rx_frame_num[15:0]    = 16'(16'h100 + i);
    i_rx_data_type[7:0]     = 8'(i);
    i_rx_file_end_flag[0]   = 1'(i);
    i_rx_checksum_flag[0]   = 1'b0;
  endtask

  function automatic logic [63:0] exp_info(input int i);
    return {1'b1, 21'b0, 8'(i), 1'(i), 1'b0, 16'(16'h100 + i), 16'(i + 1)};
  endfunction

  initial begin
    do_reset();
    chk("rst_mode", o_tx_mode, 0);
    chk("rst_irq", o_irq, 0);
    chk("rst_softrst", o_soft_rst, 0);
    chk("rst_rvalid", o_reg_rvalid, 0);
    chk("rst_cfgdone", o_tx_config_done, 0);

    // TX packet config on ch1
    wr(4'd1, OFF_TX_PACKET, 64'h2000_0005_0010_0366);
    wr(4'd1, OFF_TX_CFG, 64'h0);
    chk("tx_cfg_done", o_tx_config_done, 2'b10);
    chk("tx_body", o_tx_packet_body, 32'h0366_0000);
    chk("tx_num", o_tx_body_num, 32'h0010_0000);
    chk("tx_tail", o_tx_packet_tail, 32'h0005_0000);
    chk("tx_mode", o_tx_mode, 8'h20);
    tick();
    chk("tx_cfg_done_pulse", o_tx_config_done, 2'b00);
    rd(4'd1, OFF_TX_PACKET, d);
    chk("tx_packet_rb", d, 64'h2000_0005_0010_0366);
    chk("rvalid", o_reg_rvalid, 1);
    i_tx_status[9:0] = 10'h155;
    rd(4'd0, OFF_TX_STATUS, d);
    chk("tx_status", d, 64'h9000_0000_0000_0155);
    i_rx_status[11:6] = 6'h15;
    rd(4'd1, OFF_RX_STATUS, d);
    chk("rx_status", d, 64'ha000_0000_0000_0015);
    wr(4'd0, OFF_RX_CFG, 64'h0);
    chk("rx_cfg_done", o_rx_config_done, 2'b01);
    wr(4'd0, OFF_RX_ADDR, 64'h1234_5678);
    chk("rx_addr_out", o_rx_base_addr, 64'h0000_0000_1234_5678);

    // Interrupt path
    do_reset();
    wr(4'd0, OFF_IRQ_MASK, 64'h2);
    set_rx(0); i_rx_interrupt[0] = 1'b1; tick(); i_rx_interrupt[0] = 1'b0;
    chk("irq_1cyc", o_irq, 0);
    tick();
    chk("irq_2cyc", o_irq, 2'b01);
    rd(4'd0, OFF_IRQ_STATUS, d);
    chk("irq_status", d, 64'h2);
    i_reg_wen = 1'b1; i_reg_waddr = {4'd0, OFF_IRQ_STATUS}; i_reg_wdata = 64'h2;
    i_rx_interrupt[0] = 1'b1;
    tick();
    i_reg_wen = 1'b0; i_rx_interrupt[0] = 1'b0;
    rd(4'd0, OFF_IRQ_STATUS, d);
    chk("w1c_set_wins", d, 64'h2);
    wr(4'd0, OFF_IRQ_STATUS, 64'h2);
    rd(4'd0, OFF_IRQ_STATUS, d);
    chk("w1c_clear", d, 64'h0);
    chk("irq_drop", o_irq, 0);

    // Loss snapshot
    i_rx_status[5:0] = 6'h2b; i_sync_loss[0] = 1'b1; i_link_loss[0] = 1'b0;
    i_loss_interrupt[0] = 1'b1; tick(); i_loss_interrupt[0] = 1'b0;
    i_rx_status[5:0] = 6'h00; i_sync_loss[0] = 1'b0;
    rd(4'd0, OFF_IRQ_STATUS, d);
    chk("loss_snapshot", d, 64'h2b24);

    // FIFO overflow, push+pop while full, in-order drain
    do_reset();
    i_rx_interrupt[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_rx(i); tick();
    end
    i_rx_interrupt[0] = 1'b0;
    rd(4'd0, OFF_RX_INFO_CNT, d);
    chk("fifo_cnt_full", d, 8);
    rd(4'd0, OFF_IRQ_STATUS, d);
    chk("fifo_ovf", d, 64'ha);
    wr(4'd0, OFF_IRQ_STATUS, 64'hf);
    i_reg_ren = 1'b1; i_reg_raddr = {4'd0, OFF_RX_INFO};
    set_rx(8); i_rx_interrupt[0] = 1'b1;
    tick();
    i_reg_ren = 1'b0; i_rx_interrupt[0] = 1'b0;
    chk("pushpop_data", o_reg_rdata, exp_info(0));
    rd(4'd0, OFF_RX_INFO_CNT, d);
    chk("pushpop_cnt", d, 8);
    rd(4'd0, OFF_IRQ_STATUS, d);
    chk("pushpop_no_ovf", d, 64'h2);
    for (int i = 1; i <= 8; i++) begin
      rd(4'd0, OFF_RX_INFO, d);
      chk($sformatf("info_%0d", i), d, exp_info(i));
    end
    rd(4'd0, OFF_RX_INFO, d);
    chk("info_empty", d, 0);
    chk("info_empty_rvalid", o_reg_rvalid, 1);
    rd(4'd0, OFF_RX_INFO_CNT, d);
    chk("fifo_cnt_empty", d, 0);

    // Soft reset pulse length, restart, async abort
    wr(4'd3, OFF_SOFT_RST, 64'h1);
    n = 0;
    while (o_soft_rst && n < 1000) begin n++; tick(); end
    chk("soft_rst_len", n, 255);
    wr(4'd0, OFF_SOFT_RST, 64'h1);
    n = 0;
    while (o_soft_rst && n < 1000) begin
      n++;
      if (n == 100) begin i_reg_wen = 1'b1; i_reg_waddr = {4'd0, OFF_SOFT_RST}; end
      tick();
      i_reg_wen = 1'b0;
    end
    chk("soft_rst_restart", n, 355);
    wr(4'd1, OFF_SOFT_RST, 64'h1);
    repeat (49) tick();
    chk("soft_rst_mid", o_soft_rst, 1);
    #2 rst = 1'b1;
    #1 chk("soft_rst_async_abort", o_soft_rst, 0);
    tick(); rst = 1'b0;

    // Unmapped accesses and same-cycle read/write ordering
    wr(4'd5, OFF_TX_LEN, 64'hdead);
    wr(4'd0, 12'h018, 64'hbeef);
    chk("unmapped_wr", o_tx_total_packet, 0);
    rd(4'd5, OFF_TX_LEN, d);
    chk("bad_ch_rd", d, 0);
    chk("bad_ch_rvalid", o_reg_rvalid, 1);
    rd(4'd0, 12'h018, d);
    chk("bad_off_rd", d, 0);
    wr(4'd0, OFF_TX_LEN, 64'h1234);
    i_reg_wen = 1'b1; i_reg_waddr = {4'd0, OFF_TX_LEN}; i_reg_wdata = 64'h5678;
    i_reg_ren = 1'b1; i_reg_raddr = {4'd0, OFF_TX_LEN};
    tick();
    i_reg_wen = 1'b0; i_reg_ren = 1'b0;
    chk("rw_same_old", o_reg_rdata, 64'h1234);
    tick();
    chk("rdata_hold", o_reg_rdata, 64'h1234);
    rd(4'd0, OFF_TX_LEN, d);
    chk("rw_same_new", d, 64'h5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
